// File: rtl/flac_pkg.sv
// Shared definitions for the fixed-predictor FLAC residual encoder.
// Holds the FSM state set, default widths and the order/Rice limits.
package flac_pkg;

   localparam int SAMPLE_W_DEF = 16;
   localparam int RES_W_DEF    = 21;
   localparam int MAX_ORDER    = 4;
   localparam int MAX_RICE     = 14;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      RAW,
      CALC,
      UNARY,
      STOP,
      BINARY,
      DONE
   } state_t;

endpackage

// File: rtl/fixed_residual_calc.sv
// Combinational fixed-predictor residual (orders 0..4).
// Orders above 4 fall through to the order-4 predictor.
module fixed_residual_calc
   import flac_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int RES_W    = RES_W_DEF
) (
   input  logic        [2:0]          order_i,
   input  logic signed [SAMPLE_W-1:0] x0_i,
   input  logic signed [SAMPLE_W-1:0] x1_i,
   input  logic signed [SAMPLE_W-1:0] x2_i,
   input  logic signed [SAMPLE_W-1:0] x3_i,
   input  logic signed [SAMPLE_W-1:0] x4_i,
   output logic signed [RES_W-1:0]    res_o
);

   logic signed [RES_W-1:0] e0, e1, e2, e3, e4;

   assign e0 = RES_W'(x0_i);
   assign e1 = RES_W'(x1_i);
   assign e2 = RES_W'(x2_i);
   assign e3 = RES_W'(x3_i);
   assign e4 = RES_W'(x4_i);

   // Binomial coefficients built from shifts and adds
   always_comb begin
      res_o = e0;
      unique case (order_i)
         3'd0: res_o = e0;
         3'd1: res_o = e0 - e1;
         3'd2: res_o = e0 - (e1 <<< 1) + e2;
         3'd3: res_o = e0 - ((e1 <<< 1) + e1)
                          + ((e2 <<< 1) + e2) - e3;
         default: res_o = e0 - (e1 <<< 2)
                             + ((e2 <<< 2) + (e2 <<< 1))
                             - (e3 <<< 2) + e4;
      endcase
   end

endmodule

// File: rtl/fixed_residual_encoder.sv
// Fixed-predictor residual encoder: raw warm-up samples, then
// Rice-coded residuals, serialised one bit per handshake.
module fixed_residual_encoder
   import flac_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int RES_W    = RES_W_DEF
) (
   input  logic                       iClock,
   input  logic                       iReset,
   input  logic                       iStart,
   input  logic        [2:0]          iOrder,
   input  logic        [3:0]          iRiceParam,
   input  logic        [15:0]         iBlockSize,
   input  logic signed [SAMPLE_W-1:0] iSample,
   input  logic                       iValid,
   output logic                       oReady,
   output logic                       oBit,
   output logic                       oBitValid,
   input  logic                       iBitReady,
   output logic                       oDone
);

   localparam int U_W = RES_W + 1;
   localparam int BW  = $clog2(SAMPLE_W + 1);

   state_t                     state_q, state_d;
   logic        [2:0]          order_q, order_d;
   logic        [3:0]          k_q, k_d;
   logic        [15:0]         bsize_q, bsize_d;
   logic        [15:0]         idx_q, idx_d;
   logic                       last_q, last_d;
   logic signed [SAMPLE_W-1:0] cur_q, cur_d;
   logic signed [SAMPLE_W-1:0] h1_q, h1_d, h2_q, h2_d;
   logic signed [SAMPLE_W-1:0] h3_q, h3_d, h4_q, h4_d;
   logic        [U_W-1:0]      sr_q, sr_d;
   logic        [BW-1:0]       bcnt_q, bcnt_d;
   logic        [U_W-1:0]      cnt_q, cnt_d;

   logic signed [RES_W-1:0]    res;
   logic        [U_W-1:0]      res2;
   logic        [U_W-1:0]      u_fold;
   logic        [U_W-1:0]      quo;
   logic                       accept;
   logic                       consume;
   state_t                     end_st;

   fixed_residual_calc #(
      .SAMPLE_W (SAMPLE_W),
      .RES_W    (RES_W)
   ) u_calc (
      .order_i (order_q),
      .x0_i    (cur_q),
      .x1_i    (h1_q),
      .x2_i    (h2_q),
      .x3_i    (h3_q),
      .x4_i    (h4_q),
      .res_o   (res)
   );

   // -2r-1 is the bitwise inverse of 2r
   assign res2   = {res, 1'b0};
   assign u_fold = res[RES_W-1] ? ~res2 : res2;
   assign quo    = u_fold >> k_q;

   assign oReady    = (state_q == WAIT);
   assign oDone     = (state_q == DONE);
   assign oBitValid = (state_q == RAW) || (state_q == UNARY) ||
                      (state_q == STOP) || (state_q == BINARY);
   assign oBit      = ((state_q == RAW) || (state_q == BINARY)) ?
                      sr_q[U_W-1] : (state_q == STOP);

   assign accept  = oReady && iValid;
   assign consume = oBitValid && iBitReady;
   assign end_st  = last_q ? DONE : WAIT;

   always_comb begin
      state_d = state_q;
      order_d = order_q;
      k_d     = k_q;
      bsize_d = bsize_q;
      idx_d   = idx_q;
      last_d  = last_q;
      cur_d   = cur_q;
      h1_d    = h1_q;
      h2_d    = h2_q;
      h3_d    = h3_q;
      h4_d    = h4_q;
      sr_d    = sr_q;
      bcnt_d  = bcnt_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (iStart) begin
               order_d = (iOrder > 3'(MAX_ORDER)) ?
                         3'(MAX_ORDER) : iOrder;
               k_d     = (iRiceParam > 4'(MAX_RICE)) ?
                         4'(MAX_RICE) : iRiceParam;
               bsize_d = iBlockSize;
               idx_d   = '0;
               last_d  = 1'b0;
               cur_d   = '0;
               h1_d    = '0;
               h2_d    = '0;
               h3_d    = '0;
               h4_d    = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (accept) begin
               cur_d   = iSample;
               h1_d    = cur_q;
               h2_d    = h1_q;
               h3_d    = h2_q;
               h4_d    = h3_q;
               idx_d   = idx_q + 16'd1;
               last_d  = (idx_q + 16'd1) == bsize_q;
               sr_d    = {iSample, {(U_W-SAMPLE_W){1'b0}}};
               bcnt_d  = BW'(SAMPLE_W);
               state_d = (idx_q < 16'(order_q)) ? RAW : CALC;
            end
         end
         RAW, BINARY: begin
            if (consume) begin
               sr_d = sr_q << 1;
               if (bcnt_q == BW'(1)) state_d = end_st;
               else bcnt_d = bcnt_q - BW'(1);
            end
         end
         CALC: begin
            cnt_d   = quo;
            sr_d    = u_fold << (U_W - int'(k_q));
            bcnt_d  = BW'(k_q);
            state_d = (quo == '0) ? STOP : UNARY;
         end
         UNARY: begin
            if (consume) begin
               cnt_d = cnt_q - U_W'(1);
               if (cnt_q == U_W'(1)) state_d = STOP;
            end
         end
         STOP: begin
            if (consume) state_d = (k_q == 4'd0) ? end_st : BINARY;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         state_q <= IDLE;
         order_q <= '0;
         k_q     <= '0;
         bsize_q <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         cur_q   <= '0;
         h1_q    <= '0;
         h2_q    <= '0;
         h3_q    <= '0;
         h4_q    <= '0;
         sr_q    <= '0;
         bcnt_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         order_q <= order_d;
         k_q     <= k_d;
         bsize_q <= bsize_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         cur_q   <= cur_d;
         h1_q    <= h1_d;
         h2_q    <= h2_d;
         h3_q    <= h3_d;
         h4_q    <= h4_d;
         sr_q    <= sr_d;
         bcnt_q  <= bcnt_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fixed_residual_encoder.sv
// Bench for fixed_residual_encoder: constant vectors, corner
// sequences and random blocks against a binomial-formula model.
module tb_fixed_residual_encoder;

   logic               iClock;
   logic               iReset;
   logic               iStart;
   logic        [2:0]  iOrder;
   logic        [3:0]  iRiceParam;
   logic        [15:0] iBlockSize;
   logic signed [15:0] iSample;
   logic               iValid;
   logic               oReady;
   logic               oBit;
   logic               oBitValid;
   logic               iBitReady;
   logic               oDone;

   int checks;
   int failures;

   fixed_residual_encoder #(.SAMPLE_W(16), .RES_W(21)) dut (
      .iClock     (iClock),
      .iReset     (iReset),
      .iStart     (iStart),
      .iOrder     (iOrder),
      .iRiceParam (iRiceParam),
      .iBlockSize (iBlockSize),
      .iSample    (iSample),
      .iValid     (iValid),
      .oReady     (oReady),
      .oBit       (oBit),
      .oBitValid  (oBitValid),
      .iBitReady  (iBitReady),
      .oDone      (oDone)
   );

   initial iClock = 1'b0;
   always #5 iClock = ~iClock;

   typedef struct {
      logic [2:0]       ord;
      logic [3:0]       k;
      logic [4:0][15:0] smp;
      int               n;
      int               rmode;
      int               exp_len;
      logic [127:0]     exp;
   } vec_t;

   task automatic chk(input string name, input longint act,
                      input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Residual = sum_j (-1)^j C(order,j) x[n-j], then fold and Rice
   function automatic void model(input int ord, input int k,
                                 input int smp[$],
                                 output bit bits[$]);
      int o, kk, r, c, u, q;
      bits = {};
      o  = (ord > 4) ? 4 : ord;
      kk = (k > 14) ? 14 : k;
      for (int n = 0; n < smp.size(); n++) begin
         if (n < o) begin
            for (int b = 15; b >= 0; b--) bits.push_back(smp[n][b]);
         end else begin
            r = 0;
            c = 1;
            for (int j = 0; j <= o; j++) begin
               r += ((j % 2) != 0 ? -c : c) * smp[n-j];
               c = c * (o - j) / (j + 1);
            end
            u = (r >= 0) ? 2 * r : -2 * r - 1;
            q = u >> kk;
            repeat (q) bits.push_back(1'b0);
            bits.push_back(1'b1);
            for (int b = kk - 1; b >= 0; b--) bits.push_back(u[b]);
         end
      end
   endfunction

   // Called #1 after a rising edge; returns at the same phase.
   task automatic run_block(input int ord, input int k,
                            input int smp[$], input int rmode,
                            input bit glitch, input int abort_at,
                            output bit got[$], output int ndone,
                            output bit unstable, output bit tout,
                            output bit aborted);
      int  si, cyc;
      bit  rdy, hold, pbit, gdone;
      got = {};
      ndone = 0;
      unstable = 0;
      tout = 0;
      aborted = 0;
      si = 0;
      cyc = 0;
      hold = 0;
      pbit = 0;
      gdone = 0;
      iOrder = 3'(ord);
      iRiceParam = 4'(k);
      iBlockSize = 16'(smp.size());
      iStart = 1'b1;
      @(posedge iClock); #1;
      iStart = 1'b0;
      forever begin
         if (oDone) begin
            ndone++;
            break;
         end
         if (abort_at >= 0 && got.size() == abort_at && oBitValid) begin
            iReset = 1'b1;
            aborted = 1;
            break;
         end
         iValid = (si < smp.size());
         iSample = iValid ? 16'(smp[si]) : 16'sd0;
         iStart = 1'b0;
         if (glitch && oReady && si == 1 && !gdone) begin
            iStart = 1'b1;
            iOrder = 3'd4;
            iRiceParam = 4'd0;
            iBlockSize = 16'd1;
            gdone = 1;
         end
         case (rmode)
            0: rdy = 1'b1;
            1: rdy = (cyc % 2) == 0;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         iBitReady = rdy;
         if (hold && (!oBitValid || oBit != pbit)) unstable = 1;
         if (oBitValid && rdy) got.push_back(oBit);
         hold = oBitValid && !rdy;
         pbit = oBit;
         if (oReady && iValid) si++;
         @(posedge iClock); #1;
         cyc++;
         if (cyc > 70000) begin
            tout = 1;
            break;
         end
      end
      iValid = 1'b0;
      iBitReady = 1'b0;
      iStart = 1'b0;
      if (!tout && !aborted) begin
         repeat (3) begin
            @(posedge iClock); #1;
            if (oDone) ndone++;
         end
      end
   endtask

   task automatic check_block(input string name, input bit got[$],
                              input bit exp[$], input int ndone,
                              input bit unstable, input bit tout);
      int first;
      first = -1;
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
         if (got[i] != exp[i]) begin
            first = i;
            break;
         end
      end
      chk({name, " timeout"}, tout, 0);
      chk({name, " bit_count"}, got.size(), exp.size());
      chk({name, " first_bad_bit"}, first, -1);
      chk({name, " done_pulses"}, ndone, 1);
      chk({name, " held_bit_changed"}, unstable, 0);
   endtask

   vec_t tbl[6];

   initial begin
      bit got[$];
      bit exp[$];
      int smp[$];
      int ndone;
      bit unstable, tout, aborted;
      int ord, k, amp, n;

      checks = 0;
      failures = 0;
      iReset = 1'b1;
      iStart = 1'b0;
      iOrder = '0;
      iRiceParam = '0;
      iBlockSize = '0;
      iSample = '0;
      iValid = 1'b0;
      iBitReady = 1'b0;

      tbl[0] = '{ord: 3'd0, k: 4'd2,
                 smp: {16'd0, 16'd0, 16'd0, 16'hfffd, 16'd5},
                 n: 2, rmode: 0, exp_len: 9, exp: 128'b001100101};
      tbl[1] = '{ord: 3'd0, k: 4'd2,
                 smp: {16'd0, 16'd0, 16'd0, 16'hfffd, 16'd5},
                 n: 2, rmode: 1, exp_len: 9, exp: 128'b001100101};
      tbl[2] = '{ord: 3'd1, k: 4'd1,
                 smp: {16'd0, 16'd0, 16'd0, 16'd103, 16'd100},
                 n: 2, rmode: 0, exp_len: 21,
                 exp: 128'({16'h0064, 5'b00010})};
      tbl[3] = '{ord: 3'd2, k: 4'd2,
                 smp: {16'd0, 16'd0, 16'd4, 16'd2, 16'd1},
                 n: 3, rmode: 0, exp_len: 35,
                 exp: 128'({16'h0001, 16'h0002, 3'b110})};
      tbl[4] = '{ord: 3'd7, k: 4'd15,
                 smp: {16'd1, 16'd0, 16'd0, 16'd0, 16'd0},
                 n: 5, rmode: 0, exp_len: 79,
                 exp: 128'({64'h0, 1'b1, 14'd2})};
      tbl[5] = '{ord: 3'd3, k: 4'd0,
                 smp: {16'd0, 16'd50, 16'd40, 16'd20, 16'd10},
                 n: 4, rmode: 2, exp_len: 88,
                 exp: 128'({48'h000A_0014_0028, 40'd1})};

      repeat (3) @(posedge iClock);
      #1;
      chk("reset oReady", oReady, 0);
      chk("reset oBitValid", oBitValid, 0);
      chk("reset oBit", oBit, 0);
      chk("reset oDone", oDone, 0);
      iReset = 1'b0;
      @(posedge iClock); #1;
      chk("idle oReady", oReady, 0);
      chk("idle oBitValid", oBitValid, 0);

      for (int t = 0; t < 6; t++) begin
         smp = {};
         exp = {};
         for (int j = 0; j < tbl[t].n; j++)
            smp.push_back(int'($signed(tbl[t].smp[j])));
         for (int i = tbl[t].exp_len - 1; i >= 0; i--)
            exp.push_back(tbl[t].exp[i]);
         run_block(tbl[t].ord, tbl[t].k, smp, tbl[t].rmode, 0, -1,
                   got, ndone, unstable, tout, aborted);
         check_block($sformatf("vec%0d", t), got, exp, ndone,
                     unstable, tout);
      end

      // Start pulse while waiting for a sample must be ignored
      smp = {5, -3};
      model(0, 2, smp, exp);
      run_block(0, 2, smp, 0, 1, -1, got, ndone, unstable, tout,
                aborted);
      check_block("start_in_wait", got, exp, ndone, unstable, tout);

      // Reset in the middle of the second sample's unary run
      run_block(0, 2, smp, 0, 0, 5, got, ndone, unstable, tout,
                aborted);
      chk("abort reached", aborted, 1);
      #1;
      chk("abort oReady", oReady, 0);
      chk("abort oBitValid", oBitValid, 0);
      chk("abort oBit", oBit, 0);
      chk("abort oDone", oDone, 0);
      @(posedge iClock); #1;
      chk("abort next oBitValid", oBitValid, 0);
      iReset = 1'b0;
      ndone = 0;
      repeat (5) begin
         @(posedge iClock); #1;
         if (oDone || oReady || oBitValid) ndone++;
      end
      chk("abort stays idle", ndone, 0);
      smp = {7, -100, 33, 12};
      model(2, 3, smp, exp);
      run_block(2, 3, smp, 0, 0, -1, got, ndone, unstable, tout,
                aborted);
      check_block("after_abort", got, exp, ndone, unstable, tout);

      // Order 4, k=0: 64 raw bits then a 65534-long unary run
      smp = {0, 0, 0, 0, 32767};
      model(4, 0, smp, exp);
      run_block(4, 0, smp, 0, 0, -1, got, ndone, unstable, tout,
                aborted);
      check_block("max_unary", got, exp, ndone, unstable, tout);
      chk("max_unary length", got.size(), 64 + 65535);

      for (int t = 0; t < 8; t++) begin
         ord = $urandom_range(0, 7);
         k = $urandom_range(0, 15);
         amp = (k >= 14) ? 32767 : (1 << k) + 3;
         n = $urandom_range((ord > 4) ? 4 : ((ord < 1) ? 1 : ord), 10);
         smp = {};
         for (int j = 0; j < n; j++)
            smp.push_back(int'($urandom_range(0, 2 * amp)) - amp);
         model(ord, k, smp, exp);
         run_block(ord, k, smp, 2, 0, -1, got, ndone, unstable, tout,
                   aborted);
         check_block($sformatf("rand%0d o%0d k%0d", t, ord, k), got,
                     exp, ndone, unstable, tout);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
